// File: rtl/axis_packet_checker.sv
// AXI-Stream packet checker: arm with an expected packet, compare the received stream, report pass/errors.
// Optional first-mismatch capture ports are built when AXIS_PACKET_CHECKER_MISMATCH_CAPTURE_EN is defined.
module axis_packet_checker #(
  parameter int MTU_BYTES       = 1500,
  parameter bit AXIS_BIG_ENDIAN = 1'b0,
  parameter int DATA_WIDTH      = 64,
  parameter int USER_WIDTH      = 4
) (
  input  logic                    clk,
  input  logic                    sresetn,
  input  logic [DATA_WIDTH-1:0]   axis_packet_in_tdata,
  input  logic [DATA_WIDTH/8-1:0] axis_packet_in_tkeep,
  input  logic [USER_WIDTH-1:0]   axis_packet_in_tuser,
  input  logic                    axis_packet_in_tlast,
  input  logic                    axis_packet_in_tvalid,
  output logic                    axis_packet_in_tready,
  input  logic                    expect_req,
  input  logic [31:0]             expected_byte_length,
  input  logic [USER_WIDTH-1:0]   expected_user,
  input  logic [0:MTU_BYTES*8-1]  expected_data,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    length_err,
  output logic                    data_err,
  output logic                    user_err,
  output logic                    keep_err,
  output logic                    overflow_err
`ifdef AXIS_PACKET_CHECKER_MISMATCH_CAPTURE_EN
  ,
  output logic [31:0]             mismatch_index,
  output logic [7:0]              mismatch_rx_byte,
  output logic [7:0]              mismatch_exp_byte
`endif
);

  localparam int          NB    = DATA_WIDTH / 8;
  localparam int          IDX_W = (MTU_BYTES > 1) ? $clog2(MTU_BYTES) : 1;
  localparam logic [31:0] MTU_W = 32'(MTU_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_RECEIVE, S_REPORT} state_t;

  state_t state_q, state_d;

  logic [7:0]            exp_mem_q [MTU_BYTES];
  logic [31:0]           len_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [31:0]           cnt_q, cnt_d;

  // Sticky per-packet flags, cleared on arm.
  logic data_bad_q, keep_bad_q, ovf_q;
  // Reported flags, updated only when a packet finishes.
  logic pass_q, length_err_q, data_err_q, user_err_q, keep_err_q, overflow_err_q;

  logic          arm, beat, last_beat;
  logic [NB-1:0] keep_ord;
  logic [7:0]    byte_ord [NB];
  logic          beat_data_bad, beat_ovf, beat_keep_bad;
  logic          fin_len_bad, fin_user_bad;

`ifdef AXIS_PACKET_CHECKER_MISMATCH_CAPTURE_EN
  logic        mm_hit;
  logic [31:0] mm_idx;
  logic [7:0]  mm_rx, mm_exp;
  logic [31:0] mm_index_q;
  logic [7:0]  mm_rx_q, mm_exp_q;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!sresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (expect_req) state_d = S_RECEIVE;
      S_RECEIVE: if (last_beat)  state_d = S_REPORT;
      S_REPORT:                  state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    axis_packet_in_tready = (state_q == S_RECEIVE);
    busy                  = (state_q != S_IDLE);
    done                  = (state_q == S_REPORT);
  end

  assign arm       = (state_q == S_IDLE) && expect_req;
  assign beat      = axis_packet_in_tvalid && axis_packet_in_tready;
  assign last_beat = beat && axis_packet_in_tlast;

  // Reorder lanes so index 0 is always the first byte of the beat.
  always_comb begin
    keep_ord = '0;
    for (int j = 0; j < NB; j++) begin
      if (AXIS_BIG_ENDIAN) begin
        keep_ord[j] = axis_packet_in_tkeep[NB-1-j];
        byte_ord[j] = axis_packet_in_tdata[(NB-1-j)*8 +: 8];
      end else begin
        keep_ord[j] = axis_packet_in_tkeep[j];
        byte_ord[j] = axis_packet_in_tdata[j*8 +: 8];
      end
    end
  end

  always_comb begin
    // NOTE: blocking assignments here on purpose -- cnt_d accumulates byte offsets lane by lane.
    cnt_d         = cnt_q;
    beat_data_bad = 1'b0;
    beat_ovf      = 1'b0;
`ifdef AXIS_PACKET_CHECKER_MISMATCH_CAPTURE_EN
    mm_hit = 1'b0;
    mm_idx = '0;
    mm_rx  = '0;
    mm_exp = '0;
`endif
    for (int j = 0; j < NB; j++) begin
      if (keep_ord[j]) begin
        if (cnt_d < MTU_W) begin
          if (byte_ord[j] != exp_mem_q[cnt_d[IDX_W-1:0]]) begin
            beat_data_bad = 1'b1;
`ifdef AXIS_PACKET_CHECKER_MISMATCH_CAPTURE_EN
            if (!mm_hit) begin
              mm_hit = 1'b1;
              mm_idx = cnt_d;
              mm_rx  = byte_ord[j];
              mm_exp = exp_mem_q[cnt_d[IDX_W-1:0]];
            end
`endif
          end
        end else begin
          beat_ovf = 1'b1;
        end
        cnt_d = cnt_d + 32'd1;
      end
    end
  end

  // Keep must be a non-empty run starting at the first lane; only the last beat may be partial.
  assign beat_keep_bad = ~|keep_ord
                       | (|(keep_ord & (keep_ord + NB'(1))))
                       | (~axis_packet_in_tlast & ~&keep_ord);
  assign fin_len_bad   = (cnt_d != len_q);
  assign fin_user_bad  = (axis_packet_in_tuser != user_q);

  // NOTE: the expected-byte store is not reset; it is fully reloaded on every arm before it is read.
  always_ff @(posedge clk) begin
    if (arm) begin
      for (int k = 0; k < MTU_BYTES; k++) exp_mem_q[k] <= expected_data[k*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      len_q          <= '0;
      user_q         <= '0;
      cnt_q          <= '0;
      data_bad_q     <= 1'b0;
      keep_bad_q     <= 1'b0;
      ovf_q          <= 1'b0;
      pass_q         <= 1'b0;
      length_err_q   <= 1'b0;
      data_err_q     <= 1'b0;
      user_err_q     <= 1'b0;
      keep_err_q     <= 1'b0;
      overflow_err_q <= 1'b0;
    end else if (arm) begin
      len_q      <= expected_byte_length;
      user_q     <= expected_user;
      cnt_q      <= '0;
      data_bad_q <= 1'b0;
      keep_bad_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (beat) begin
      cnt_q      <= cnt_d;
      data_bad_q <= data_bad_q | beat_data_bad;
      keep_bad_q <= keep_bad_q | beat_keep_bad;
      ovf_q      <= ovf_q | beat_ovf;
      if (axis_packet_in_tlast) begin
        length_err_q   <= fin_len_bad;
        data_err_q     <= data_bad_q | beat_data_bad;
        user_err_q     <= fin_user_bad;
        keep_err_q     <= keep_bad_q | beat_keep_bad;
        overflow_err_q <= ovf_q | beat_ovf;
        pass_q         <= ~(fin_len_bad | fin_user_bad | data_bad_q | beat_data_bad
                            | keep_bad_q | beat_keep_bad | ovf_q | beat_ovf);
      end
    end
  end

  assign pass         = pass_q;
  assign length_err   = length_err_q;
  assign data_err     = data_err_q;
  assign user_err     = user_err_q;
  assign keep_err     = keep_err_q;
  assign overflow_err = overflow_err_q;

`ifdef AXIS_PACKET_CHECKER_MISMATCH_CAPTURE_EN
  // First mismatch of the packet only; data_bad_q marks that one was already taken.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      mm_index_q <= '0;
      mm_rx_q    <= '0;
      mm_exp_q   <= '0;
    end else if (arm) begin
      mm_index_q <= '0;
      mm_rx_q    <= '0;
      mm_exp_q   <= '0;
    end else if (beat && mm_hit && !data_bad_q) begin
      mm_index_q <= mm_idx;
      mm_rx_q    <= mm_rx;
      mm_exp_q   <= mm_exp;
    end
  end

  assign mismatch_index    = mm_index_q;
  assign mismatch_rx_byte  = mm_rx_q;
  assign mismatch_exp_byte = mm_exp_q;
`endif

endmodule

// File: tb/tb_axis_packet_checker.sv
// Directed bench for axis_packet_checker (MTU 16 bytes, 64-bit little-endian stream, 4-bit tuser).
module tb_axis_packet_checker;
  localparam int MTU = 16;
  localparam int DW  = 64;
  localparam int NB  = DW / 8;
  localparam int UW  = 4;

  logic              clk = 1'b0;
  logic              sresetn;
  logic [DW-1:0]     tdata;
  logic [NB-1:0]     tkeep;
  logic [UW-1:0]     tuser;
  logic              tlast, tvalid, tready;
  logic              expect_req;
  logic [31:0]       expected_byte_length;
  logic [UW-1:0]     expected_user;
  logic [0:MTU*8-1]  expected_data;
  logic              busy, done, pass, length_err, data_err, user_err, keep_err, overflow_err;
`ifdef AXIS_PACKET_CHECKER_MISMATCH_CAPTURE_EN
  logic [31:0]       mismatch_index;
  logic [7:0]        mismatch_rx_byte, mismatch_exp_byte;
`endif

  logic [0:MTU*8-1]  exp_data;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_packet_checker #(
    .MTU_BYTES(MTU), .AXIS_BIG_ENDIAN(1'b0), .DATA_WIDTH(DW), .USER_WIDTH(UW)
  ) dut (
    .clk                  (clk),
    .sresetn              (sresetn),
    .axis_packet_in_tdata (tdata),
    .axis_packet_in_tkeep (tkeep),
    .axis_packet_in_tuser (tuser),
    .axis_packet_in_tlast (tlast),
    .axis_packet_in_tvalid(tvalid),
    .axis_packet_in_tready(tready),
    .expect_req           (expect_req),
    .expected_byte_length (expected_byte_length),
    .expected_user        (expected_user),
    .expected_data        (expected_data),
    .busy                 (busy),
    .done                 (done),
    .pass                 (pass),
    .length_err           (length_err),
    .data_err             (data_err),
    .user_err             (user_err),
    .keep_err             (keep_err),
    .overflow_err         (overflow_err)
`ifdef AXIS_PACKET_CHECKER_MISMATCH_CAPTURE_EN
    ,
    .mismatch_index       (mismatch_index),
    .mismatch_rx_byte     (mismatch_rx_byte),
    .mismatch_exp_byte    (mismatch_exp_byte)
`endif
  );

  // Packet byte n is 0x10+n; a beat starting at offset s carries bytes s..s+7.
  function automatic logic [DW-1:0] mk(input int start);
    logic [DW-1:0] r;
    for (int j = 0; j < NB; j++) r[j*8 +: 8] = 8'(8'h10 + start + j);
    return r;
  endfunction

  // {done, pass, length_err, data_err, user_err, keep_err, overflow_err}
  function automatic logic [6:0] report();
    return {done, pass, length_err, data_err, user_err, keep_err, overflow_err};
  endfunction

  // All tasks start and finish on a falling edge.
  task automatic arm(input logic [31:0] len, input logic [UW-1:0] u);
    expected_byte_length = len;
    expected_user        = u;
    expected_data        = exp_data;
    expect_req           = 1'b1;
    @(negedge clk);
    expect_req = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [NB-1:0] k,
                           input logic last, input logic [UW-1:0] u, output bit accepted);
    int n;
    tdata  = d;
    tkeep  = k;
    tlast  = last;
    tuser  = u;
    tvalid = 1'b1;
    n = 0;
    while (tready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    accepted = (tready === 1'b1);
    checks++;
    if (!accepted) begin
      failures++;
      $display("FAIL handshake_timeout: tready=%b after %0d cycles, required 1", tready, n);
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic test_reset();
    sresetn    = 1'b0;
    tvalid     = 1'b0;
    tlast      = 1'b0;
    tkeep      = '0;
    tdata      = '0;
    tuser      = '0;
    expect_req = 1'b1;
    expected_byte_length = '0;
    expected_user        = '0;
    expected_data        = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tready, busy, report()} !== 9'b0) begin
      failures++;
      $display("FAIL reset_state: {tready,busy,done,pass,errs}=%b, required 0", {tready, busy, report()});
    end
    expect_req = 1'b0;
    sresetn    = 1'b1;
    @(negedge clk);
    checks++;
    if ({tready, busy} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: {tready,busy}=%b, required 00", {tready, busy});
    end
  endtask

  task automatic test_clean();
    bit ok;
    arm(13, 4'h5);
    checks++;
    if ({busy, tready} !== 2'b11) begin
      failures++;
      $display("FAIL arm_busy: {busy,tready}=%b, required 11", {busy, tready});
    end
    send_beat(mk(0), 8'hFF, 1'b0, 4'h5, ok);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL early_done: done=%b, required 0", done);
    end
    send_beat(mk(8), 8'h1F, 1'b1, 4'h5, ok);
    checks++;
    if (report() !== 7'b1100000) begin
      failures++;
      $display("FAIL clean_report: got %b, required 1100000", report());
    end
    @(negedge clk);
    checks++;
    if ({done, busy, pass} !== 3'b001) begin
      failures++;
      $display("FAIL clean_hold: {done,busy,pass}=%b, required 001", {done, busy, pass});
    end
  endtask

  task automatic test_data_err();
    bit ok;
    logic [DW-1:0] d;
    arm(13, 4'h5);
    send_beat(mk(0), 8'hFF, 1'b0, 4'h5, ok);
    d = mk(8);
    d[15:8] = d[15:8] ^ 8'hFF;  // packet byte 9: 0x19 -> 0xE6
    send_beat(d, 8'h1F, 1'b1, 4'h5, ok);
    checks++;
    if (report() !== 7'b1001000) begin
      failures++;
      $display("FAIL data_err_report: got %b, required 1001000", report());
    end
`ifdef AXIS_PACKET_CHECKER_MISMATCH_CAPTURE_EN
    checks++;
    if ({mismatch_index, mismatch_rx_byte, mismatch_exp_byte} !== {32'd9, 8'hE6, 8'h19}) begin
      failures++;
      $display("FAIL mismatch_capture: idx=%0d rx=%h exp=%h, required 9 e6 19",
               mismatch_index, mismatch_rx_byte, mismatch_exp_byte);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_length_user();
    bit ok;
    arm(13, 4'h5);
    send_beat(mk(0), 8'hFF, 1'b0, 4'h5, ok);
    send_beat(mk(8), 8'hFF, 1'b1, 4'h5, ok);
    checks++;
    if (report() !== 7'b1010000) begin
      failures++;
      $display("FAIL length_err_report: got %b, required 1010000", report());
    end
    @(negedge clk);
    arm(13, 4'h5);
    send_beat(mk(0), 8'hFF, 1'b0, 4'h5, ok);
    send_beat(mk(8), 8'h1F, 1'b1, 4'hA, ok);
    checks++;
    if (report() !== 7'b1000100) begin
      failures++;
      $display("FAIL user_err_report: got %b, required 1000100", report());
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    bit ok0, ok1, ok2;
    arm(13, 4'h5);
    send_beat(mk(0),  8'hFF, 1'b0, 4'h5, ok0);
    send_beat(mk(8),  8'hFF, 1'b0, 4'h5, ok1);
    send_beat(mk(16), 8'hFF, 1'b1, 4'h5, ok2);
    checks++;
    if ({ok0, ok1, ok2} !== 3'b111) begin
      failures++;
      $display("FAIL overflow_accept: accepted=%b, required 111", {ok0, ok1, ok2});
    end
    checks++;
    if (report() !== 7'b1010001) begin
      failures++;
      $display("FAIL overflow_report: got %b, required 1010001", report());
    end
    @(negedge clk);
  endtask

  task automatic test_keep();
    bit ok;
    logic [DW-1:0] d;
    // Partial keep on a non-last beat.
    arm(12, 4'h5);
    send_beat(mk(0), 8'h0F, 1'b0, 4'h5, ok);
    send_beat(mk(4), 8'hFF, 1'b1, 4'h5, ok);
    checks++;
    if (report() !== 7'b1000010) begin
      failures++;
      $display("FAIL keep_partial_report: got %b, required 1000010", report());
    end
    @(negedge clk);
    // Gap in keep on the last beat: two bytes kept, total 10.
    arm(10, 4'h5);
    send_beat(mk(0), 8'hFF, 1'b0, 4'h5, ok);
    d = mk(8);
    d[23:16] = 8'h19;
    send_beat(d, 8'h05, 1'b1, 4'h5, ok);
    checks++;
    if ({done, length_err, user_err, keep_err, overflow_err} !== 5'b10010) begin
      failures++;
      $display("FAIL keep_gap_report: {done,len,user,keep,ovf}=%b, required 10010",
               {done, length_err, user_err, keep_err, overflow_err});
    end
    @(negedge clk);
    // Zero-kept-byte tlast beat as the whole packet.
    arm(0, 4'h5);
    send_beat(mk(0), 8'h00, 1'b1, 4'h5, ok);
    checks++;
    if (report() !== 7'b1000010) begin
      failures++;
      $display("FAIL keep_zero_report: got %b, required 1000010", report());
    end
    @(negedge clk);
    // Single-beat clean packet.
    arm(5, 4'h5);
    send_beat(mk(0), 8'h1F, 1'b1, 4'h5, ok);
    checks++;
    if (report() !== 7'b1100000) begin
      failures++;
      $display("FAIL one_beat_report: got %b, required 1100000", report());
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_req();
    bit ok;
    arm(13, 4'h5);
    send_beat(mk(0), 8'hFF, 1'b0, 4'h5, ok);
    expected_byte_length = 32'd8;
    expected_user        = 4'hA;
    expected_data        = ~exp_data;
    expect_req           = 1'b1;
    @(negedge clk);
    expect_req = 1'b0;
    checks++;
    if ({busy, tready} !== 2'b11) begin
      failures++;
      $display("FAIL ignore_req_state: {busy,tready}=%b, required 11", {busy, tready});
    end
    send_beat(mk(8), 8'h1F, 1'b1, 4'h5, ok);
    checks++;
    if (report() !== 7'b1100000) begin
      failures++;
      $display("FAIL ignore_req_report: got %b, required 1100000", report());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic bad;
    arm(13, 4'h5);
    send_beat(mk(0), 8'hFF, 1'b0, 4'h5, ok);
    tdata   = mk(8);
    tkeep   = 8'h1F;
    tlast   = 1'b1;
    tuser   = 4'h5;
    tvalid  = 1'b1;
    sresetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({tready, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_state: {tready,busy,done}=%b, required 000", {tready, busy, done});
    end
    sresetn = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (tready !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_no_accept: tready/done seen high=%b, required 0", bad);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    @(negedge clk);
    arm(13, 4'h5);
    send_beat(mk(0), 8'hFF, 1'b0, 4'h5, ok);
    send_beat(mk(8), 8'h1F, 1'b1, 4'h5, ok);
    checks++;
    if (report() !== 7'b1100000) begin
      failures++;
      $display("FAIL rearm_report: got %b, required 1100000", report());
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int n = 0; n < MTU; n++) exp_data[n*8 +: 8] = 8'(8'h10 + n);
    test_reset();
    test_clean();
    test_data_err();
    test_length_user();
    test_overflow();
    test_keep();
    test_ignore_req();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_packet_checker.md
AXIS_PACKET_CHECKER -- requirements
Module: axis_packet_checker

Interface
REQ-001 The block SHALL have parameter MTU_BYTES, default 1500, meaning maximum packet length in bytes checked.
REQ-002 The block SHALL have parameter AXIS_BIG_ENDIAN, default 1'b0; 0 = first byte in tdata[7:0], 1 = first byte in the most-significant tdata byte.
REQ-003 The block SHALL have port axis_packet_in.clk, input, 1, the single clock (carried in AXIS_int).
REQ-004 The block SHALL have port axis_packet_in.sresetn, input, 1, synchronous active-low reset (carried in AXIS_int).
REQ-005 The block SHALL have port axis_packet_in, AXIS_int.Slave, DATA_WIDTH/USER_WIDTH from the interface, packet under test.
REQ-006 The block SHALL have port expect_req, input, 1, arm a check with the current expected_* values.
REQ-007 The block SHALL have port expected_byte_length, input, int, expected packet length in bytes.
REQ-008 The block SHALL have port expected_user, input, USER_WIDTH, expected tuser on the tlast beat.
REQ-009 The block SHALL have port expected_data, input, [0:MTU_BYTES*8-1], expected bytes; byte n is bits [n*8 +: 8].
REQ-010 The block SHALL have port busy, output, 1, high from arm until report.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse when a result is valid.
REQ-012 The block SHALL have port pass, output, 1, registered result, valid with done and held until next done.
REQ-013 The block SHALL have ports length_err, data_err, user_err, keep_err, overflow_err, outputs, 1 each, registered error flags, held like pass.

Function
REQ-014 The block SHALL implement states IDLE, RECEIVE, REPORT.
REQ-015 IDLE: tready=0; expect_req=1 latches all expected_* into local registers, clears error flags, goes to RECEIVE next cycle.
REQ-016 RECEIVE: tready=1; every tvalid&tready beat is checked; tlast handshake goes to REPORT.
REQ-017 REPORT: one cycle; done=1, pass = no error flag set; returns to IDLE.
REQ-018 busy SHALL be 1 in RECEIVE and REPORT, 0 in IDLE.
REQ-019 expect_req outside IDLE SHALL be ignored with no effect on latched values.
REQ-020 Byte count SHALL be a 32-bit counter of valid bytes (popcount of tkeep per beat), zeroed on arm.
REQ-021 tkeep SHALL be contiguous from the first-byte lane; any gap, or partial tkeep on a non-tlast beat, SHALL set keep_err.
REQ-022 Each kept byte at packet offset k < MTU_BYTES SHALL be compared with latched byte k; mismatch sets data_err.
REQ-023 Bytes at offset >= MTU_BYTES SHALL set overflow_err, not be compared, and still be accepted until tlast.
REQ-024 At tlast, final byte count != latched length SHALL set length_err; tuser != latched user SHALL set user_err.
REQ-025 Errors SHALL be sticky within a packet; the first tlast after arm always ends the check.
REQ-026 done SHALL assert exactly one cycle after the tlast handshake cycle.
REQ-027 A 1-beat packet (tlast on first beat) and a zero-kept-byte tlast beat (length 0 + keep_err) SHALL both report normally.

Reset
REQ-028 On sresetn=0 (sampled on clk edge) state SHALL go to IDLE; tready, busy, done, pass and all error flags SHALL be 0.
REQ-029 Reset mid-packet SHALL abandon the check with no done pulse; remaining beats of that packet are not accepted until re-armed.

Configuration
REQ-030 With AXIS_PACKET_CHECKER_MISMATCH_CAPTURE_EN defined, the block SHALL add outputs mismatch_index (32b), mismatch_rx_byte (8b), mismatch_exp_byte (8b) capturing the first data mismatch of the packet, held until next arm, reset to 0.
REQ-031 Without AXIS_PACKET_CHECKER_MISMATCH_CAPTURE_EN, those ports SHALL not exist and no capture logic SHALL be built.

Verification
REQ-032 DATA_WIDTH=64, arm length 13, matching data/user, beats tkeep 0xFF then 0x1F with tlast -> done one cycle after tlast, pass=1, all errors 0.
REQ-033 Same packet with byte 9 corrupted -> pass=0, data_err=1 only; with capture enabled, mismatch_index=9 and rx/exp bytes reported.
REQ-034 Expect 13, send 16 bytes (0xFF,0xFF) -> length_err=1; send 13 bytes with tuser differing -> user_err=1 only.
REQ-035 MTU_BYTES=16, send 24 bytes -> overflow_err=1, length_err=1, all 3 beats accepted, done after tlast.
REQ-036 Non-last beat tkeep 0x0F, or last beat tkeep 0x05 -> keep_err=1; expect_req pulsed during RECEIVE -> latched length unchanged.
REQ-037 Assert sresetn=0 mid-packet -> next cycle tready=0, busy=0, no done; re-arm and send clean packet -> pass=1.
